// File: rtl/init_seq_pkg.sv
// Shared definitions for the init/reset sequencer: FSM state codes and the
// counter width helper used to size saturating counters.
package init_seq_pkg;

    typedef enum logic [2:0] {
        ST_POR_WAIT  = 3'd0,
        ST_INIT_WAIT = 3'd1,
        ST_LOCK_WAIT = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_t;

    // Bits needed to hold every value 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/init_bit_sync.sv
// Single-bit multi-flop synchronizer for the asynchronous init-monitor and
// CCC status lines; synchronous active-high reset clears every stage.
module init_bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/init_reset_sequencer.sv
// Ordered reset release for the MIV_RV32 subsystem: fabric peripherals first,
// then the core after a fixed delay, with sticky timeout/lock-loss flags.
module init_reset_sequencer
    import init_seq_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int LOCK_FILTER         = 16,
    parameter int RELEASE_DELAY       = 64,
    parameter int INIT_TIMEOUT_CYCLES = 1048576,
    parameter int REQUIRE_SRAM        = 1,
    parameter int REQUIRE_USRAM       = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FABRIC_POR_N,
    input  logic       DEVICE_INIT_DONE,
    input  logic       SRAM_INIT_DONE,
    input  logic       USRAM_INIT_DONE,
    input  logic       PLL_LOCK,
    output logic       FABRIC_RESET_N,
    output logic       CORE_RESET,
    output logic       INIT_DONE,
    output logic       INIT_TIMEOUT,
    output logic       LOCK_LOST,
    output logic [2:0] STATE
);

    localparam int N_IN = 5;
    localparam int LW   = cnt_width(LOCK_FILTER);
    localparam int RW   = cnt_width(RELEASE_DELAY);
    localparam int TW   = cnt_width(INIT_TIMEOUT_CYCLES);

    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FILTER);
    localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_DELAY - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(INIT_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_SET   = TW'(INIT_TIMEOUT_CYCLES - 2);

    logic [N_IN-1:0] async_in;
    logic [N_IN-1:0] synced;

    assign async_in = {PLL_LOCK, USRAM_INIT_DONE, SRAM_INIT_DONE,
                       DEVICE_INIT_DONE, FABRIC_POR_N};

    for (genvar i = 0; i < N_IN; i++) begin : g_sync
        init_bit_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk (CLK),
            .rst (RESET),
            .d   (async_in[i]),
            .q   (synced[i])
        );
    end

    logic por_s;
    logic dev_s;
    logic sram_s;
    logic usram_s;
    logic lock_s;

    assign por_s   = synced[0];
    assign dev_s   = synced[1];
    assign sram_s  = synced[2];
    assign usram_s = synced[3];
    assign lock_s  = synced[4];

    logic init_ok;
    assign init_ok = dev_s
                   & (sram_s  | (REQUIRE_SRAM  == 0))
                   & (usram_s | (REQUIRE_USRAM == 0));

    // Lock filter; gating with lock_s drops lock_ok in the very cycle the
    // synced lock falls, before the counter itself has been cleared.
    logic [LW-1:0] lock_cnt;
    logic          lock_ok;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_cnt <= '0;
        end else if (!lock_s) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LOCK_MAX) begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end

    assign lock_ok = lock_s && (lock_cnt == LOCK_MAX);

    seq_state_t    state;
    logic [RW-1:0] rel_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= ST_POR_WAIT;
            FABRIC_RESET_N <= 1'b0;
            CORE_RESET     <= 1'b1;
            INIT_DONE      <= 1'b0;
            LOCK_LOST      <= 1'b0;
            rel_cnt        <= '0;
        end else if (!por_s) begin
            state          <= ST_POR_WAIT;
            FABRIC_RESET_N <= 1'b0;
            CORE_RESET     <= 1'b1;
            INIT_DONE      <= 1'b0;
        end else if (!init_ok &&
                     (state inside {ST_LOCK_WAIT, ST_RELEASE, ST_RUN})) begin
            state          <= ST_INIT_WAIT;
            FABRIC_RESET_N <= 1'b0;
            CORE_RESET     <= 1'b1;
            INIT_DONE      <= 1'b0;
        end else if (!lock_ok && (state inside {ST_RELEASE, ST_RUN})) begin
            state          <= ST_LOCK_WAIT;
            FABRIC_RESET_N <= 1'b0;
            CORE_RESET     <= 1'b1;
            INIT_DONE      <= 1'b0;
            LOCK_LOST      <= 1'b1;
        end else begin
            case (state)
                ST_POR_WAIT: begin
                    state <= ST_INIT_WAIT;
                end
                ST_INIT_WAIT: begin
                    if (init_ok) begin
                        state <= ST_LOCK_WAIT;
                    end
                end
                ST_LOCK_WAIT: begin
                    if (lock_ok) begin
                        state          <= ST_RELEASE;
                        FABRIC_RESET_N <= 1'b1;
                        rel_cnt        <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (rel_cnt == REL_LAST) begin
                        state      <= ST_RUN;
                        CORE_RESET <= 1'b0;
                        INIT_DONE  <= 1'b1;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state          <= ST_POR_WAIT;
                    FABRIC_RESET_N <= 1'b0;
                    CORE_RESET     <= 1'b1;
                    INIT_DONE      <= 1'b0;
                end
            endcase
        end
    end

    // Timeout counter; the flag is set on the edge that brings to_cnt to
    // INIT_TIMEOUT_CYCLES-1, so both are visible together (needs >= 2).
    logic [TW-1:0] to_cnt;
    logic          in_wait;

    assign in_wait = (state == ST_INIT_WAIT) || (state == ST_LOCK_WAIT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            to_cnt       <= '0;
            INIT_TIMEOUT <= 1'b0;
        end else if (in_wait) begin
            if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_cnt == TO_SET) begin
                INIT_TIMEOUT <= 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Directed bench for init_reset_sequencer: expected output-change events
// (cycle stamp + output vector) are queued by the stimulus and popped by monitors.
module tb_init_reset_sequencer;

  logic clk;
  logic rst, rst2;
  logic por_n, dev, sram, usram, lock;

  logic       frn_a, core_a, done_a, to_a, ll_a;
  logic [2:0] st_a;
  logic       frn_b, core_b, done_b, to_b, ll_b;
  logic [2:0] st_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // event word: {cycle[15:0], state[2:0], fabric_reset_n, core_reset, init_done, init_timeout, lock_lost}
  logic [23:0] exp_q[$];
  logic [23:0] exp2_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  init_reset_sequencer #(
    .INIT_TIMEOUT_CYCLES(100)
  ) dut (
    .CLK              (clk),
    .RESET            (rst),
    .FABRIC_POR_N     (por_n),
    .DEVICE_INIT_DONE (dev),
    .SRAM_INIT_DONE   (sram),
    .USRAM_INIT_DONE  (usram),
    .PLL_LOCK         (lock),
    .FABRIC_RESET_N   (frn_a),
    .CORE_RESET       (core_a),
    .INIT_DONE        (done_a),
    .INIT_TIMEOUT     (to_a),
    .LOCK_LOST        (ll_a),
    .STATE            (st_a)
  );

  init_reset_sequencer #(
    .INIT_TIMEOUT_CYCLES(100),
    .REQUIRE_SRAM(0)
  ) dut_nosram (
    .CLK              (clk),
    .RESET            (rst2),
    .FABRIC_POR_N     (por_n),
    .DEVICE_INIT_DONE (dev),
    .SRAM_INIT_DONE   (sram),
    .USRAM_INIT_DONE  (usram),
    .PLL_LOCK         (lock),
    .FABRIC_RESET_N   (frn_b),
    .CORE_RESET       (core_b),
    .INIT_DONE        (done_b),
    .INIT_TIMEOUT     (to_b),
    .LOCK_LOST        (ll_b),
    .STATE            (st_b)
  );

  task automatic at_cycle(input int n);
    while (cyc != n) @(negedge clk);
  endtask

  task automatic exp_a(input int c, input logic [2:0] st, input logic frn,
                       input logic core, input logic done, input logic to, input logic ll);
    logic [15:0] cw;
    cw = c[15:0];
    exp_q.push_back({cw, st, frn, core, done, to, ll});
  endtask

  task automatic exp_b(input int c, input logic [2:0] st, input logic frn,
                       input logic core, input logic done, input logic to, input logic ll);
    logic [15:0] cw;
    cw = c[15:0];
    exp2_q.push_back({cw, st, frn, core, done, to, ll});
  endtask

  task automatic check_ev(input string name, input logic [23:0] e, input logic [7:0] cur);
    logic [23:0] got;
    got = {cyc[15:0], cur};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s event: got cycle %0d vec %b, required cycle %0d vec %b",
               name, got[23:8], got[7:0], e[23:8], e[7:0]);
    end
  endtask

  logic [7:0] prev_a = 'x;
  logic [7:0] prev_b = 'x;

  always @(negedge clk) begin
    logic [7:0] cur;
    cur = {st_a, frn_a, core_a, done_a, to_a, ll_a};
    if (cur !== prev_a) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main unexpected_change: got cycle %0d vec %b, required no change", cyc, cur);
      end else begin
        check_ev("main", exp_q.pop_front(), cur);
      end
    end
    prev_a = cur;
  end

  always @(negedge clk) begin
    logic [7:0] cur;
    cur = {st_b, frn_b, core_b, done_b, to_b, ll_b};
    if (cur !== prev_b) begin
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL nosram unexpected_change: got cycle %0d vec %b, required no change", cyc, cur);
      end else begin
        check_ev("nosram", exp2_q.pop_front(), cur);
      end
    end
    prev_b = cur;
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    por_n = 1'b0; dev = 1'b0; sram = 1'b0; usram = 1'b0; lock = 1'b0;
    exp_a(1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_b(1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    at_cycle(2);
    rst = 1'b0;

    // clean boot
    at_cycle(10);  por_n = 1'b1;
    exp_a(13, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    at_cycle(50);  dev = 1'b1; sram = 1'b1; usram = 1'b1;
    exp_a(53, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    at_cycle(80);  lock = 1'b1;
    exp_a(99, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_a(163, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // lock glitch in RUN, then full re-release
    at_cycle(200); lock = 1'b0;
    exp_a(203, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    at_cycle(203); lock = 1'b1;
    exp_a(222, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_a(286, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // second glitch to reach RELEASE, then POR at rel_cnt 30
    at_cycle(300); lock = 1'b0;
    exp_a(303, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    at_cycle(303); lock = 1'b1;
    exp_a(322, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    at_cycle(352); por_n = 1'b0;
    exp_a(355, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    at_cycle(360); por_n = 1'b1;
    exp_a(363, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_a(364, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_a(365, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_a(429, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // RESET for one cycle in RUN, then clean-boot timing offset by 450
    at_cycle(450);
    rst = 1'b1; por_n = 1'b0; dev = 1'b0; sram = 1'b0; usram = 1'b0; lock = 1'b0;
    exp_a(451, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    at_cycle(451); rst = 1'b0;
    at_cycle(460); por_n = 1'b1;
    exp_a(463, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    at_cycle(500); dev = 1'b1; sram = 1'b1; usram = 1'b1;
    exp_a(503, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    at_cycle(530); lock = 1'b1;
    exp_a(549, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_a(613, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // POR loss and lock loss together in RUN: POR wins, LOCK_LOST stays 0
    at_cycle(630); por_n = 1'b0; lock = 1'b0;
    exp_a(633, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // missing SRAM: main instance times out and waits, the other boots
    at_cycle(635); rst2 = 1'b0;
    at_cycle(640); sram = 1'b0; por_n = 1'b1; lock = 1'b1;
    exp_a(643, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_a(742, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_b(643, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_b(644, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_b(659, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_b(723, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    at_cycle(800);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL main missing_events: got %0d pending, required 0", exp_q.size());
    end
    checks++;
    if (exp2_q.size() != 0) begin
      errors++;
      $display("FAIL nosram missing_events: got %0d pending, required 0", exp2_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
